kvs_req_arb: RTL
================

Name: kvs_req_arb

Overview:
- Shares the single KVS lookup port of the database block between the two Ethernet requesters, ETH0 and ETH1.
- Runs in the db_clk domain, between the per-port packet parsers and the database top-level.
- Round-robin arbitration issues one request per cycle into the database.
- An in-order source-tag FIFO routes each database response back to the port that issued the request.
- Bounds the number of outstanding lookups.

Parameters:
- KEY_SIZE, 96, key width in bits.
- FLAG_SIZE, 4, flag width in bits (request and response).
- MAX_OUTST, 8, maximum lookups in flight; must be a power of 2.
- OUTST_W, 3, log2(MAX_OUTST).

Ports:
- clk  in  1  db_clk.
- rst  in  1  synchronous, active-high reset.
- req0_key  in  KEY_SIZE  ETH0 request key.
- req0_flag  in  FLAG_SIZE  ETH0 request flag.
- req0_valid  in  1  ETH0 request valid; held until accepted.
- req0_ready  out  1  ETH0 request accepted this cycle when valid&ready.
- req1_key, req1_flag, req1_valid, req1_ready: same as above, for ETH1.
- db_in_key  out  KEY_SIZE  key to database.
- db_in_flag  out  FLAG_SIZE  flag to database.
- db_in_valid  out  1  one-cycle request strobe to database.
- db_out_valid  in  1  database response strobe; responses return in request order.
- db_out_flag  in  FLAG_SIZE  database response flag.
- rsp0_valid  out  1  response strobe to ETH0.
- rsp0_flag  out  FLAG_SIZE  response flag to ETH0.
- rsp1_valid, rsp1_flag: same as above, for ETH1.
- outst_cnt  out  OUTST_W+1  lookups currently in flight.
- err_orphan  out  1  sticky: a response arrived with no outstanding tag.
- orphan_cnt  out  16  count of orphan responses; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0, tag FIFO emptied, outst_cnt=0, last_gnt=1 so ETH0 wins the first contention. Reset clears everything mid-operation; any response arriving after reset with the FIFO empty is treated as an orphan.
- Arbiter state: a single register last_gnt (0 = ETH0 last served, 1 = ETH1 last served).
  - Only req0_valid set: grant 0.
  - Only req1_valid set: grant 1.
  - Both set: grant ~last_gnt.
  - Neither set: no grant; last_gnt unchanged.
- full = (outst_cnt == MAX_OUTST).
- reqN_ready = granted(N) & ~full & ~rst. reqN_ready is combinational from valid, last_gnt and outst_cnt. At most one ready is high per cycle.
- On accept (valid&ready):
  - last_gnt <= N.
  - db_in_key/db_in_flag <= reqN_key/reqN_flag.
  - db_in_valid <= 1 for exactly the next cycle.
  - Tag N is pushed into the FIFO.
  - Latency from accept to db_in_valid: 1 cycle.
  - A requester may accept on back-to-back cycles when the other port is idle.
- db_in_key/db_in_flag hold their last value when db_in_valid=0.
- On db_out_valid with FIFO non-empty:
  - Pop the head tag T.
  - rspT_valid <= 1 and rspT_flag <= db_out_flag, on the next cycle.
  - The other port's rsp_valid stays 0.
  - Latency from response to rsp: 1 cycle.
- On db_out_valid with FIFO empty (no pop in the same cycle): no rsp strobe; err_orphan <= 1 (sticky until rst); orphan_cnt increments, saturating.
- Push and pop in the same cycle: outst_cnt unchanged; FIFO pointers both advance. A pop on an empty FIFO is never combined with a push from that cycle; the orphan check uses the count before the update.
- outst_cnt: +1 on push only, -1 on pop only, unchanged on both or neither. Range 0..MAX_OUTST.
- Full: both readies held low. An accept is re-enabled in the cycle after a pop makes outst_cnt < MAX_OUTST; the combinational ready sees the updated count.
- FIFO implementation: read/write pointers of width OUTST_W that wrap naturally. Full/empty is derived from outst_cnt, not from the pointers.
- Fairness: under continuous contention the grants strictly alternate 0,1,0,1…; neither port waits more than 1 grant.

Test Plan:
- Reset then idle -> all outputs 0, outst_cnt=0; first contending cycle with both valid grants ETH0 (req0_ready=1, req1_ready=0).
- Both ports valid for 6 cycles, database idle -> grant order 0,1,0,1,0,1; db_in_valid high cycles 2..7; outst_cnt reaches 6.
- Only ETH0 valid for 10 cycles, MAX_OUTST=8, no responses -> 8 accepts, then req0_ready=0 with outst_cnt=8. One db_out_valid -> rsp0_valid 1 cycle later, and an accept in the same cycle as the pop-driven count drop restores outst_cnt=8.
- Interleaved issue 0,1,1,0, then 4 responses with flags 1,2,3,4 -> rsp0 gets 1, rsp1 gets 2 and 3, rsp0 gets 4, each 1 cycle after its db_out_valid.
- Push and pop in the same cycle at outst_cnt=3 -> outst_cnt stays 3; the response is routed to the correct port.
- db_out_valid with FIFO empty -> no rsp strobe, err_orphan=1, orphan_cnt=1. Assert rst mid-traffic -> outst_cnt=0, err_orphan=0, readies low during rst.

Source files
------------

// File: rtl/kvs_req_arb.sv
`default_nettype none
// ==== kvs_req_arb : round-robin ETH0/ETH1 share of the KVS lookup port with in-order response routing (rev 1.0) ====
module kvs_req_arb #(
   parameter int KEY_SIZE  = 96,
   parameter int FLAG_SIZE = 4,
   parameter int MAX_OUTST = 8,
   parameter int OUTST_W   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [KEY_SIZE-1:0]  req0_key,
   input  logic [FLAG_SIZE-1:0] req0_flag,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [KEY_SIZE-1:0]  req1_key,
   input  logic [FLAG_SIZE-1:0] req1_flag,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   output logic [KEY_SIZE-1:0]  db_in_key,
   output logic [FLAG_SIZE-1:0] db_in_flag,
   output logic                 db_in_valid,
   input  logic                 db_out_valid,
   input  logic [FLAG_SIZE-1:0] db_out_flag,
   output logic                 rsp0_valid,
   output logic [FLAG_SIZE-1:0] rsp0_flag,
   output logic                 rsp1_valid,
   output logic [FLAG_SIZE-1:0] rsp1_flag,
   output logic [OUTST_W:0]     outst_cnt,
   output logic                 err_orphan,
   output logic [15:0]          orphan_cnt
);

   localparam logic [OUTST_W:0] C_MAX = MAX_OUTST[OUTST_W:0];
   localparam logic [OUTST_W:0] C_ONE = {{OUTST_W{1'b0}}, 1'b1};

   logic                 r_last_gnt;
   logic [MAX_OUTST-1:0] r_tags;
   logic [OUTST_W-1:0]   r_wr_ptr;
   logic [OUTST_W-1:0]   r_rd_ptr;
   logic [OUTST_W:0]     r_cnt;

   logic w_want0, w_want1, w_full, w_empty;
   logic w_acc0, w_acc1, w_push, w_pop, w_orphan, w_head;

   always_comb begin
      w_want0    = req0_valid & (~req1_valid | r_last_gnt);
      w_want1    = req1_valid & (~req0_valid | ~r_last_gnt);
      w_full     = (r_cnt == C_MAX);
      w_empty    = (r_cnt == '0);
      req0_ready = w_want0 & ~w_full & ~rst;
      req1_ready = w_want1 & ~w_full & ~rst;
      w_acc0     = req0_valid & req0_ready;
      w_acc1     = req1_valid & req1_ready;
      w_push     = w_acc0 | w_acc1;
      // Emptiness is judged on the pre-update count, so a same-cycle push never rescues an orphan.
      w_pop      = db_out_valid & ~w_empty;
      w_orphan   = db_out_valid & w_empty;
      w_head     = r_tags[r_rd_ptr];
   end

   assign outst_cnt = r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_gnt  <= 1'b1;
         r_tags      <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_cnt       <= '0;
         db_in_key   <= '0;
         db_in_flag  <= '0;
         db_in_valid <= 1'b0;
         rsp0_valid  <= 1'b0;
         rsp0_flag   <= '0;
         rsp1_valid  <= 1'b0;
         rsp1_flag   <= '0;
         err_orphan  <= 1'b0;
         orphan_cnt  <= '0;
      end else begin
         db_in_valid <= w_push;
         if (w_push) begin
            r_last_gnt         <= w_acc1;
            db_in_key          <= w_acc1 ? req1_key  : req0_key;
            db_in_flag         <= w_acc1 ? req1_flag : req0_flag;
            r_tags[r_wr_ptr]   <= w_acc1;
            r_wr_ptr           <= r_wr_ptr + 1'b1;
         end

         rsp0_valid <= w_pop & ~w_head;
         rsp1_valid <= w_pop &  w_head;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_head) rsp1_flag <= db_out_flag;
            else        rsp0_flag <= db_out_flag;
         end

         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + C_ONE;
            2'b01:   r_cnt <= r_cnt - C_ONE;
            default: r_cnt <= r_cnt;
         endcase

         if (w_orphan) begin
            err_orphan <= 1'b1;
            if (~&orphan_cnt) orphan_cnt <= orphan_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire
